// File: rtl/gba_sound_pkg.sv
// Shared Direct Sound definitions: channel ids, FIFO sizing defaults
// and SOUNDCNT_H bit positions used by the scheduler and register block.
package gba_sound_pkg;

   typedef enum logic {
      CH_A = 1'b0,
      CH_B = 1'b1
   } ch_t;

   localparam int FIFO_WORDS_DEF = 8;
   localparam int DMA_THRESH_DEF = 4;

   localparam int SNDH_TMR_A = 10;
   localparam int SNDH_RST_A = 11;
   localparam int SNDH_TMR_B = 14;
   localparam int SNDH_RST_B = 15;

endpackage

// File: rtl/gba_sound_chan_ctr.sv
// Per-channel sequencing state: pending tick count, byte lane within
// the FIFO head word, and the level-held DMA refill request.
module gba_sound_chan_ctr
   import gba_sound_pkg::*;
#(
   parameter int LW         = 4,
   parameter int DMA_THRESH = DMA_THRESH_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          tick,
   input  logic          clr,
   input  logic          srv,
   input  logic          ack,
   input  logic [LW-1:0] level,
   output logic          want,
   output logic [1:0]    byte_idx,
   output logic          dma_req
);

   logic [1:0] pend;
   logic [1:0] pend_nxt;
   logic       add;
   logic       fire;
   logic       dset;

   // Request service when something is pending, counting this cycle's tick.
   always_comb begin
      want     = en && !clr && ((pend != 2'd0) || tick);
      add      = tick && (pend != 2'd3);
      pend_nxt = pend + {1'b0, add} - {1'b0, srv};
      fire     = srv && (level != '0);
      dset     = 1'b0;
      if (fire && (byte_idx == 2'd3)) begin
         dset = (level - LW'(1)) <= LW'(DMA_THRESH);
      end
   end

   // Channel state update; FIFO reset overrides tick, service and ack.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend     <= 2'd0;
         byte_idx <= 2'd0;
         dma_req  <= 1'b0;
      end else if (en) begin
         if (clr) begin
            pend     <= 2'd0;
            byte_idx <= 2'd0;
            dma_req  <= 1'b0;
         end else begin
            pend <= pend_nxt;
            if (fire) begin
               byte_idx <= byte_idx + 2'd1;
            end
            if (dset) begin
               dma_req <= 1'b1;
            end else if (ack) begin
               dma_req <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/gba_sound_fifo_sched.sv
// Routes timer overflows to Direct Sound FIFOs A/B, arbitrates the
// shared FIFO read port and drives sample, pop and refill strobes.
module gba_sound_fifo_sched
   import gba_sound_pkg::*;
#(
   parameter int FIFO_WORDS = FIFO_WORDS_DEF,
   parameter int DMA_THRESH = DMA_THRESH_DEF,
   localparam int LW        = $clog2(FIFO_WORDS + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          gb_on,
   input  logic          tick_t0,
   input  logic          tick_t1,
   input  logic          sel_a,
   input  logic          sel_b,
   input  logic          fifo_rst_a,
   input  logic          fifo_rst_b,
   input  logic [LW-1:0] level_a,
   input  logic [LW-1:0] level_b,
   output logic          smp_stb,
   output logic          smp_ch,
   output logic [1:0]    smp_byte,
   output logic          pop,
   output logic          dma_req_a,
   output logic          dma_req_b,
   input  logic          dma_ack_a,
   input  logic          dma_ack_b,
   output logic          underrun_a,
   output logic          underrun_b
);

   logic       tick_a;
   logic       tick_b;
   logic       want_a;
   logic       want_b;
   logic       srv_a;
   logic       srv_b;
   logic [1:0] byte_a;
   logic [1:0] byte_b;
   logic [1:0] cur_byte;
   logic       fire;
   logic       wrap;
   ch_t        last;

   assign tick_a = sel_a ? tick_t1 : tick_t0;
   assign tick_b = sel_b ? tick_t1 : tick_t0;

   gba_sound_chan_ctr #(
      .LW         (LW),
      .DMA_THRESH (DMA_THRESH)
   ) u_chan_a (
      .clk      (clk),
      .reset    (reset),
      .en       (gb_on),
      .tick     (tick_a),
      .clr      (fifo_rst_a),
      .srv      (srv_a),
      .ack      (dma_ack_a),
      .level    (level_a),
      .want     (want_a),
      .byte_idx (byte_a),
      .dma_req  (dma_req_a)
   );

   gba_sound_chan_ctr #(
      .LW         (LW),
      .DMA_THRESH (DMA_THRESH)
   ) u_chan_b (
      .clk      (clk),
      .reset    (reset),
      .en       (gb_on),
      .tick     (tick_b),
      .clr      (fifo_rst_b),
      .srv      (srv_b),
      .ack      (dma_ack_b),
      .level    (level_b),
      .want     (want_b),
      .byte_idx (byte_b),
      .dma_req  (dma_req_b)
   );

   // Round-robin grant of the single read port; on conflict the
   // channel not served last wins.
   always_comb begin
      srv_a    = want_a && (!want_b || (last == CH_B));
      srv_b    = want_b && (!want_a || (last == CH_A));
      fire     = (srv_a && (level_a != '0)) || (srv_b && (level_b != '0));
      cur_byte = srv_b ? byte_b : byte_a;
      wrap     = fire && (cur_byte == 2'd3);
   end

   // Registered strobes and grant history.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         smp_stb    <= 1'b0;
         smp_ch     <= 1'b0;
         smp_byte   <= 2'd0;
         pop        <= 1'b0;
         underrun_a <= 1'b0;
         underrun_b <= 1'b0;
         last       <= CH_B;
      end else if (!gb_on) begin
         smp_stb    <= 1'b0;
         pop        <= 1'b0;
         underrun_a <= 1'b0;
         underrun_b <= 1'b0;
      end else begin
         smp_stb    <= fire;
         pop        <= wrap;
         underrun_a <= srv_a && (level_a == '0);
         underrun_b <= srv_b && (level_b == '0);
         if (srv_a) begin
            last <= CH_A;
         end else if (srv_b) begin
            last <= CH_B;
         end
         if (fire) begin
            smp_ch   <= srv_b;
            smp_byte <= cur_byte;
         end
      end
   end

endmodule

// File: tb/tb_gba_sound_fifo_sched.sv
// Scoreboard bench for gba_sound_fifo_sched: a cycle model predicts
// each registered output set, a negedge monitor compares it.
module tb_gba_sound_fifo_sched;

   localparam int THRESH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       gb_on = 1'b0;
   logic       tick_t0 = 1'b0;
   logic       tick_t1 = 1'b0;
   logic       sel_a = 1'b0;
   logic       sel_b = 1'b0;
   logic       fifo_rst_a = 1'b0;
   logic       fifo_rst_b = 1'b0;
   logic [3:0] level_a = 4'd0;
   logic [3:0] level_b = 4'd0;
   logic       dma_ack_a = 1'b0;
   logic       dma_ack_b = 1'b0;
   logic       smp_stb;
   logic       smp_ch;
   logic [1:0] smp_byte;
   logic       pop;
   logic       dma_req_a;
   logic       dma_req_b;
   logic       underrun_a;
   logic       underrun_b;

   gba_sound_fifo_sched dut (
      .clk        (clk),
      .reset      (reset),
      .gb_on      (gb_on),
      .tick_t0    (tick_t0),
      .tick_t1    (tick_t1),
      .sel_a      (sel_a),
      .sel_b      (sel_b),
      .fifo_rst_a (fifo_rst_a),
      .fifo_rst_b (fifo_rst_b),
      .level_a    (level_a),
      .level_b    (level_b),
      .smp_stb    (smp_stb),
      .smp_ch     (smp_ch),
      .smp_byte   (smp_byte),
      .pop        (pop),
      .dma_req_a  (dma_req_a),
      .dma_req_b  (dma_req_b),
      .dma_ack_a  (dma_ack_a),
      .dma_ack_b  (dma_ack_b),
      .underrun_a (underrun_a),
      .underrun_b (underrun_b)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      bit       stb;
      bit       ch;
      bit [1:0] byt;
      bit       pop;
      bit       ua;
      bit       ub;
      bit       da;
      bit       db;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;

   int pend[2];
   int bytei[2];
   bit dreq[2];
   bit last_b;

   function automatic exp_t actual();
      exp_t a;
      a.stb = smp_stb;
      a.ch  = smp_ch;
      a.byt = smp_byte;
      a.pop = pop;
      a.ua  = underrun_a;
      a.ub  = underrun_b;
      a.da  = dma_req_a;
      a.db  = dma_req_b;
      return a;
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < 2; c++) begin
         pend[c]  = 0;
         bytei[c] = 0;
         dreq[c]  = 1'b0;
      end
      last_b = 1'b1;
   endfunction

   // Cycle-level behaviour from the channel rules, using plain integers.
   function automatic void model_step(
      bit on, bit t0, bit t1, bit sa, bit sb, bit ra, bit rb,
      int la, int lb, bit aa, bit ab);
      exp_t e;
      int   tk[2];
      bit   rs[2];
      int   lv[2];
      bit   ak[2];
      bit   cand[2];
      bit   set[2];
      int   win;
      e = '0;
      if (on) begin
         tk[0] = sa ? int'(t1) : int'(t0);
         tk[1] = sb ? int'(t1) : int'(t0);
         rs[0] = ra;
         rs[1] = rb;
         lv[0] = la;
         lv[1] = lb;
         ak[0] = aa;
         ak[1] = ab;
         win = -1;
         for (int c = 0; c < 2; c++) begin
            cand[c] = !rs[c] && (pend[c] + tk[c] > 0);
            set[c]  = 1'b0;
         end
         if (cand[0] && cand[1]) win = last_b ? 0 : 1;
         else if (cand[0]) win = 0;
         else if (cand[1]) win = 1;
         if (win >= 0) begin
            last_b = (win == 1);
            if (lv[win] == 0) begin
               if (win == 0) e.ua = 1'b1;
               else e.ub = 1'b1;
            end else begin
               e.stb = 1'b1;
               e.ch  = (win == 1);
               e.byt = 2'(bytei[win]);
               if (bytei[win] == 3) begin
                  e.pop = 1'b1;
                  if (lv[win] - 1 <= THRESH) set[win] = 1'b1;
               end
               bytei[win] = (bytei[win] + 1) % 4;
            end
         end
         for (int c = 0; c < 2; c++) begin
            if (rs[c]) begin
               pend[c]  = 0;
               bytei[c] = 0;
               dreq[c]  = 1'b0;
            end else begin
               if (pend[c] < 3) pend[c] = pend[c] + tk[c];
               if (win == c) pend[c] = pend[c] - 1;
               if (set[c]) dreq[c] = 1'b1;
               else if (ak[c]) dreq[c] = 1'b0;
            end
         end
      end
      e.da = dreq[0];
      e.db = dreq[1];
      sb_q.push_back(e);
   endfunction

   task automatic drive(
      input bit on, input bit t0, input bit t1,
      input bit sa, input bit sb, input bit ra, input bit rb,
      input int la, input int lb, input bit aa, input bit ab);
      @(negedge clk);
      #1;
      gb_on      = on;
      tick_t0    = t0;
      tick_t1    = t1;
      sel_a      = sa;
      sel_b      = sb;
      fifo_rst_a = ra;
      fifo_rst_b = rb;
      level_a    = 4'(la);
      level_b    = 4'(lb);
      dma_ack_a  = aa;
      dma_ack_b  = ab;
      model_step(on, t0, t1, sa, sb, ra, rb, la, lb, aa, ab);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 1, 0, 0, 8, 8, 0, 0);
   endtask

   task automatic check_zero(input string name);
      exp_t a;
      a = actual();
      checks++;
      if (a != '0) begin
         failures++;
         $display("FAIL %s got=%b want=%b", name, a, 9'b0);
      end
   endtask

   // Monitor: pop the prediction for the edge just past and compare.
   always @(negedge clk) begin
      exp_t e;
      exp_t a;
      exp_t m;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         a = actual();
         m = '1;
         if (!e.stb) begin
            m.ch  = 1'b0;
            m.byt = 2'b00;
         end
         checks++;
         if ((a & m) != (e & m)) begin
            failures++;
            $display("FAIL outputs t=%0t got=%b want=%b (stb ch byt pop ua ub da db)",
                     $time, a, e);
         end
      end
   end

   initial begin
      exp_t e;
      model_reset();
      #1;
      check_zero("reset_state");
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b1;

      // Four A ticks at a full FIFO: bytes 0..3, pop on the last, no refill.
      for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 1, 0, 0, 8, 8, 0, 0);
      idle(1);

      // Pop at level 5 raises the request; ack drops it.
      for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 1, 0, 0, 5, 8, 0, 0);
      drive(1, 0, 0, 0, 1, 0, 0, 5, 8, 1, 0);
      idle(1);
      // Ack coinciding with a new set keeps the request high.
      for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 1, 0, 0, 5, 8, 0, 0);
      drive(1, 0, 0, 0, 1, 0, 0, 5, 8, 0, 0);
      for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 1, 0, 0, 5, 8, 0, 0);
      drive(1, 1, 0, 0, 1, 0, 0, 5, 8, 1, 0);
      idle(2);

      // Shared timer 0 conflict: alternating grants, pending saturates.
      for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 0, 0, 0, 8, 8, 0, 0);
      idle(8);

      // B underrun on an empty FIFO.
      drive(1, 0, 1, 0, 1, 0, 0, 8, 0, 0, 0);
      drive(1, 0, 1, 0, 1, 0, 0, 8, 8, 0, 0);
      idle(2);

      // Build dma_req_a and pending A, then FIFO reset with a tick.
      for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 1, 0, 0, 3, 8, 0, 0);
      for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0, 0, 0, 3, 8, 0, 0);
      drive(1, 1, 0, 0, 0, 1, 0, 3, 8, 0, 0);
      idle(6);

      // Asynchronous reset right after a strobe.
      drive(1, 1, 0, 0, 1, 0, 0, 8, 8, 0, 0);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (smp_stb !== e.stb) begin
         failures++;
         $display("FAIL pre_reset_stb got=%b want=%b", smp_stb, e.stb);
      end
      tick_t0 = 1'b0;
      reset = 1'b0;
      #1;
      check_zero("async_reset");
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) drive(0, 1, 1, 0, 1, 0, 0, 8, 8, 0, 0);
      idle(4);

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(9, 0) != 0,
               $urandom_range(2, 0) == 0,
               $urandom_range(2, 0) == 0,
               $urandom_range(1, 0) == 1,
               $urandom_range(1, 0) == 1,
               $urandom_range(29, 0) == 0,
               $urandom_range(29, 0) == 0,
               ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(8, 1)),
               ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(8, 1)),
               $urandom_range(9, 0) == 0,
               $urandom_range(9, 0) == 0);
      end
      idle(4);
      @(negedge clk);
      #2;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain got=%0d want=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
